// File: rtl/arb_rr_ctrl_cond.sv
// Round-robin arbiter/controller for the conditional mux/demux datapath.
// Picks one non-empty input FIFO whose head word targets an output FIFO
// that is not almost full. It drives the one-hot pop/push selects for that
// transfer, and it tracks an observational state and per-output push counts.
module arb_rr_ctrl_cond #(
  parameter int FIFO_UNITS = 4,
  parameter int DEST_W     = 2,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [FIFO_UNITS-1:0]        fifo_empty,
  input  logic [FIFO_UNITS-1:0]        fifo_almost_full,
  input  logic [FIFO_UNITS*DEST_W-1:0] head_dest,
  output logic [FIFO_UNITS-1:0]        arb_pop,
  output logic [FIFO_UNITS-1:0]        arb_push,
  output logic [1:0]                   state,
  output logic                         idle,
  output logic [FIFO_UNITS*CNT_W-1:0]  push_cnt
);

  localparam int PTR_W = (FIFO_UNITS > 1) ? $clog2(FIFO_UNITS) : 1;
  // Unit count sized to match the wrap arithmetic on the pointer and the
  // destination range check.
  localparam logic [PTR_W:0]  UNITS_P = (PTR_W+1)'(FIFO_UNITS);
  localparam logic [DEST_W:0] UNITS_D = (DEST_W+1)'(FIFO_UNITS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2,
    ST_PAUSE  = 2'd3
  } state_t;

  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        rr_ptr_nxt;
  state_t                  state_q;
  state_t                  state_d;
  logic [DEST_W-1:0]       dest [FIFO_UNITS];
  logic [FIFO_UNITS-1:0]   elig;
  logic [2*FIFO_UNITS-1:0] elig_dbl;
  logic [FIFO_UNITS-1:0]   elig_rot;
  logic [PTR_W:0]          offset;
  logic [PTR_W:0]          grant_sum;
  logic [PTR_W:0]          ptr_inc;
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant_vld;
  logic [CNT_W-1:0]        cnt [FIFO_UNITS];

  // Unpack the head-word destination of each input lane.
  always_comb begin
    for (int i = 0; i < FIFO_UNITS; i++) begin
      dest[i] = head_dest[i*DEST_W +: DEST_W];
    end
  end

  // A lane is eligible when it holds data and its destination can accept a
  // word; empty always wins over a destination that frees up in the same
  // cycle. An out-of-range destination (only possible when FIFO_UNITS is
  // not a power of two) is never eligible.
  always_comb begin
    for (int i = 0; i < FIFO_UNITS; i++) begin
      elig[i] = 1'b0;
      if (!fifo_empty[i] && ({1'b0, dest[i]} < UNITS_D)) begin
        elig[i] = !fifo_almost_full[dest[i]];
      end
    end
  end

  // Rotate the eligibility vector so rr_ptr lands at bit 0, take the lowest
  // set bit as an offset, then map the offset back to an absolute lane.
  // Blocked lanes simply carry a 0 and are skipped.
  always_comb begin
    elig_dbl  = {elig, elig} >> rr_ptr;
    elig_rot  = elig_dbl[FIFO_UNITS-1:0];
    offset    = '0;
    for (int k = FIFO_UNITS - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        offset = (PTR_W+1)'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr} + offset;
    if (grant_sum >= UNITS_P) begin
      grant_sum = grant_sum - UNITS_P;
    end
    grant_idx = grant_sum[PTR_W-1:0];
    ptr_inc   = grant_sum + 1'b1;
    if (ptr_inc >= UNITS_P) begin
      ptr_inc = ptr_inc - UNITS_P;
    end
    rr_ptr_nxt = ptr_inc[PTR_W-1:0];
    grant_vld  = !reset && enable && (|elig);
  end

  // Zero-latency one-hot selects; both stay 0 without a grant, including
  // every cycle that reset is held.
  always_comb begin
    arb_pop  = '0;
    arb_push = '0;
    if (grant_vld) begin
      arb_pop[grant_idx]        = 1'b1;
      arb_push[dest[grant_idx]] = 1'b1;
    end
  end

  // Round-robin pointer: moves just past the granted lane, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next observational state from the current-cycle inputs; pause outranks
  // everything, then all-empty, then whether anything can move.
  always_comb begin
    state_d = ST_STALL;
    if (!enable) begin
      state_d = ST_PAUSE;
    end else if (&fifo_empty) begin
      state_d = ST_IDLE;
    end else if (|elig) begin
      state_d = ST_ACTIVE;
    end
  end

  // State register with idle registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idle    <= 1'b1;
    end else begin
      state_q <= state_d;
      idle    <= (state_d == ST_IDLE);
    end
  end

  assign state = state_q;

  // Per-output push counters; they wrap naturally and hold while disabled
  // because no push is issued then.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < FIFO_UNITS; j++) begin
        cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < FIFO_UNITS; j++) begin
        if (arb_push[j]) begin
          cnt[j] <= cnt[j] + 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < FIFO_UNITS; j++) begin : g_cnt_pack
    assign push_cnt[j*CNT_W +: CNT_W] = cnt[j];
  end

endmodule
